// File: rtl/md_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | md_pkg                                                                      |
// | Operation encodings and classification helpers for the multiply/divide unit.|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package md_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTHI  = 3'd5;
    localparam md_op_t MD_MTLO  = 3'd6;

    // Ops that touch HI/LO through this unit (mfhi/mflo read the outputs and never start it).
    function automatic logic is_md_class(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

    function automatic logic is_multi_cycle(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | md_arith                                                                    |
// | Combinational multiply/divide datapath producing the HI/LO result pair.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0]        w_prod_s;
    logic [2*WIDTH-1:0]        w_prod_u;
    logic                      w_b_zero;
    logic                      w_ovf;
    logic [WIDTH-1:0]          w_div_b;
    logic signed [WIDTH-1:0]   w_quo_s;
    logic signed [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]          w_quo_u;
    logic [WIDTH-1:0]          w_rem_u;

    assign w_prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Zero and MIN/-1 divisors are steered to 1 so the divider never sees an undefined case.
    assign w_b_zero = (b == '0);
    assign w_ovf    = (a == c_MIN) && (b == '1);
    assign w_div_b  = (w_b_zero || w_ovf) ? c_ONE : b;

    assign w_quo_s = $signed(a) / $signed(w_div_b);
    assign w_rem_s = $signed(a) % $signed(w_div_b);
    assign w_quo_u = a / w_div_b;
    assign w_rem_u = a % w_div_b;

    always_comb begin
        res_hi      = '0;
        res_lo      = '0;
        div_by_zero = is_div(op) && w_b_zero;
        case (op)
            MD_MULT:  {res_hi, res_lo} = w_prod_s;
            MD_MULTU: {res_hi, res_lo} = w_prod_u;
            MD_DIV: begin
                if (w_ovf) begin
                    res_hi = '0;
                    res_lo = c_MIN;
                end else begin
                    res_hi = w_rem_s;
                    res_lo = w_quo_s;
                end
            end
            MD_DIVU: begin
                res_hi = w_rem_u;
                res_lo = w_quo_u;
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | md_unit                                                                     |
// | EX-stage multiply/divide unit owning HI/LO, with multi-cycle busy/done.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic               r_done;
    logic               w_accept;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_div_by_zero;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op          (op),
        .a           (src_a),
        .b           (src_b),
        .res_hi      (w_res_hi),
        .res_lo      (w_res_lo),
        .div_by_zero (w_div_by_zero)
    );

    assign w_accept = start && (r_state == S_IDLE) && is_md_class(op);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept && is_multi_cycle(op)) begin
                    // A zero divisor commits the current HI/LO, leaving them unchanged.
                    r_pend_hi <= w_div_by_zero ? r_hi : w_res_hi;
                    r_pend_lo <= w_div_by_zero ? r_lo : w_res_lo;
                    r_cnt     <= is_div(op) ? c_CNT_W'(DIV_CYCLES - 1)
                                            : c_CNT_W'(MULT_CYCLES - 1);
                end else if (w_accept && (op == MD_MTHI)) begin
                    r_hi <= src_a;
                end else if (w_accept && (op == MD_MTLO)) begin
                    r_lo <= src_a;
                end
            end else begin
                if (r_cnt == '0) begin
                    r_hi   <= r_pend_hi;
                    r_lo   <= r_pend_lo;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && is_multi_cycle(op)) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_md_unit                                                                  |
// | Directed self-checking bench for md_unit with hand-computed results.        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    // Issue a multi-cycle op now and follow it through to its commit cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        start = 1'b1; op = o; src_a = a; src_b = b;
        step();
        start = 1'b0; op = MD_NONE;
        check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        check({tag, "_done_low"},  {63'd0, done}, 64'd0);
        check({tag, "_hi_held"},   {32'd0, hi}, {32'd0, m_hi});
        wait_idle(n);
        check({tag, "_busy_cycles"}, 64'(n), 64'(ncyc));
        check({tag, "_done_pulse"},  {63'd0, done}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        reset = 1'b1; start = 1'b0; op = MD_NONE; src_a = '0; src_b = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_hi",   {32'd0, hi}, 64'd0);
        check("rst_lo",   {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);

        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        step();
        check("multu_done_fall", {63'd0, done}, 64'd0);

        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // Back-to-back: issued in the cycle where busy has just dropped.
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        start = 1'b1; op = MD_MTHI; src_a = 32'h1234_5678; src_b = 32'h0;
        step();
        check("mthi_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mthi_lo",   {32'd0, lo}, 64'hFFFF_FFFD);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        op = MD_MTLO; src_a = 32'h9ABC_DEF0;
        step();
        start = 1'b0; op = MD_NONE;
        check("mtlo_lo",   {32'd0, lo}, 64'h9ABC_DEF0);
        check("mtlo_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mtlo_done", {63'd0, done}, 64'd0);

        start = 1'b1; op = MD_NONE; src_a = 32'hDEAD_BEEF;
        step();
        start = 1'b1; op = 3'd7;
        step();
        start = 1'b0;
        check("nop_hi",   {32'd0, hi}, 64'h1234_5678);
        check("nop_lo",   {32'd0, lo}, 64'h9ABC_DEF0);
        check("nop_busy", {63'd0, busy}, 64'd0);

        start = 1'b1; op = MD_MTHI; src_a = 32'h11;
        step();
        op = MD_MTLO; src_a = 32'h22;
        step();
        start = 1'b0; op = MD_NONE;
        m_hi = 32'h11;
        m_lo = 32'h22;
        run_op("divu0", MD_DIVU, 32'h1234, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Start while busy must be ignored.
        start = 1'b1; op = MD_MULT; src_a = 32'd100; src_b = 32'd3;
        step();
        start = 1'b0; op = MD_NONE;
        step();
        start = 1'b1; op = MD_DIVU; src_a = 32'd1000; src_b = 32'd7;
        step();
        start = 1'b0; op = MD_NONE;
        wait_idle(n);
        check("ign_busy_cycles", 64'(n + 2), 64'd5);
        check("ign_done", {63'd0, done}, 64'd1);
        check("ign_hi",   {32'd0, hi}, 64'd0);
        check("ign_lo",   {32'd0, lo}, 64'd300);
        step();
        check("ign_no_restart", {63'd0, busy}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd300;

        start = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
        step();
        start = 1'b0; op = MD_NONE;
        step();
        step();
        step();
        check("rstrun_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstrun_busy", {63'd0, busy}, 64'd0);
        check("rstrun_hi",   {32'd0, hi}, 64'd0);
        check("rstrun_lo",   {32'd0, lo}, 64'd0);
        check("rstrun_done", {63'd0, done}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op("post_rst", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 32'h1, 32'h0);
        step();
        check("post_rst_done_fall", {63'd0, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
